// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Outputs are decoded from the registered state plus op/funct/zero.
module mc_ctrl #(
  parameter bit BNE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       extop,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next     = S_FETCH;
    extop      = 1'b1;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        irwrite    = 1'b1;
        pcen       = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RT:        w_next = S_RTEX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI, OP_SLTI,
          OP_ANDI, OP_ORI: w_next = S_IMMEX;
          OP_J:         w_next = S_JUMP;
          OP_BNE: begin
            if (BNE_EN) begin
              w_next = S_BRANCH;
            end else begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          end
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        w_next     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        w_next  = S_RTWB;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_RTWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        instr_done = 1'b1;
        pcen       = (op == OP_BNE) ? ~zero : zero;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_IMMWB;
        case (op)
          OP_SLTI: alucontrol = ALU_SLT;
          OP_ANDI: begin
            alucontrol = ALU_AND;
            extop      = 1'b0;
          end
          OP_ORI: begin
            alucontrol = ALU_OR;
            extop      = 1'b0;
          end
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction summaries predicted
// from the ISA rules and compared against observed cycles.
module tb_mc_ctrl;

  typedef struct packed {
    logic [19:0] tr;
    logic [2:0]  cyc;
    logic [1:0]  regw;
    logic [1:0]  memw;
    logic [1:0]  pcen;
    logic [1:0]  irw;
    logic [1:0]  ill;
    logic [1:0]  iord;
    logic [2:0]  alu;
    logic        ext;
    logic [2:0]  src;
    logic [1:0]  pcsrc;
    logic [1:0]  wb;
  } rec_t;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic rec_t blank();
    rec_t r;
    r       = '0;
    r.alu   = 3'b011;
    r.ext   = 1'b1;
    r.src   = 3'b111;
    r.wb    = 2'b11;
    return r;
  endfunction

  // Instruction-level model: trace of state codes, event counts and
  // the datapath controls seen in the third (execute) cycle.
  function automatic rec_t model(logic [5:0] o, logic [5:0] f,
                                 logic z, bit bne_en);
    rec_t r;
    logic [2:0] fa;
    bit fok;
    r      = blank();
    r.irw  = 2'd1;
    r.pcen = 2'd1;
    fok    = 1'b1;
    fa     = 3'b000;
    case (f)
      6'h20: fa = 3'b010;
      6'h22: fa = 3'b110;
      6'h24: fa = 3'b000;
      6'h25: fa = 3'b001;
      6'h2a: fa = 3'b111;
      default: fok = 1'b0;
    endcase
    if (o == 6'b100011) begin
      r.tr = 20'h01234; r.cyc = 3'd5; r.regw = 2'd1; r.iord = 2'd1;
      r.alu = 3'b010; r.src = 3'b110; r.wb = 2'b01;
    end else if (o == 6'b101011) begin
      r.tr = 20'h00125; r.cyc = 3'd4; r.memw = 2'd1; r.iord = 2'd1;
      r.alu = 3'b010; r.src = 3'b110;
    end else if (o == 6'b000000) begin
      r.src = 3'b100;
      if (fok) begin
        r.tr = 20'h00167; r.cyc = 3'd4; r.regw = 2'd1;
        r.alu = fa; r.wb = 2'b10;
      end else begin
        r.tr = 20'h00016; r.cyc = 3'd3; r.ill = 2'd1; r.alu = 3'b000;
      end
    end else if (o == 6'b000100 || (o == 6'b000101 && bne_en)) begin
      r.tr = 20'h00018; r.cyc = 3'd3; r.alu = 3'b110; r.src = 3'b100;
      r.pcsrc = 2'b01;
      if ((o == 6'b000100) ? z : !z) r.pcen = 2'd2;
    end else if (o == 6'b001000 || o == 6'b001010 ||
                 o == 6'b001100 || o == 6'b001101) begin
      r.tr = 20'h0019a; r.cyc = 3'd4; r.regw = 2'd1; r.src = 3'b110;
      r.wb = 2'b00;
      case (o)
        6'b001000: r.alu = 3'b010;
        6'b001010: r.alu = 3'b111;
        6'b001100: begin r.alu = 3'b000; r.ext = 1'b0; end
        default:   begin r.alu = 3'b001; r.ext = 1'b0; end
      endcase
    end else if (o == 6'b000010) begin
      r.tr = 20'h0001b; r.cyc = 3'd3; r.alu = 3'b000; r.src = 3'b000;
      r.pcsrc = 2'b10; r.pcen = 2'd2;
    end else begin
      r.tr = 20'h00001; r.cyc = 3'd2; r.ill = 2'd1;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic       rst, zero;
    logic [5:0] op, funct;
    logic       extop, iord, memwrite, irwrite, regdst, memtoreg;
    logic       regwrite, alusrca, pcen, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    rec_t       q [$];
    rec_t       a;
    logic       mon_en;

    mc_ctrl #(.BNE_EN(g == 1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .extop(extop), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
      .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always @(negedge clk) begin
      if (mon_en) begin
        if (a.cyc == 3'd2) begin
          a.alu = alucontrol;
          a.ext = extop;
          a.src = {alusrca, alusrcb};
        end
        a.tr   = {a.tr[15:0], state};
        a.regw = a.regw + 2'(regwrite);
        a.memw = a.memw + 2'(memwrite);
        a.pcen = a.pcen + 2'(pcen);
        a.irw  = a.irw + 2'(irwrite);
        a.ill  = a.ill + 2'(illegal);
        a.iord = a.iord + 2'(iord);
        if (regwrite) a.wb = {regdst, memtoreg};
        a.cyc = a.cyc + 3'd1;
        if (instr_done) begin
          a.pcsrc = pcsrc;
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL dut%0d instr: unexpected done got %h", g, a);
          end else begin
            rec_t e;
            e = q.pop_front();
            if (a !== e) begin
              n_bad++;
              $display("FAIL dut%0d instr op=%b: got %h expected %h",
                       g, op, a, e);
            end
          end
          a = blank();
        end else if (a.cyc == 3'd7) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dut%0d watchdog: got no done in 7 cycles", g);
          a = blank();
        end
      end
    end

    task automatic issue(logic [5:0] o, logic [5:0] f, logic z);
      rec_t e;
      e = model(o, f, z, g == 1);
      q.push_back(e);
      op    = o;
      funct = f;
      zero  = z;
      repeat (int'(e.cyc)) @(posedge clk);
      #1;
    endtask

    initial begin
      logic [5:0] ops [11];
      logic [5:0] fns [5];
      logic [5:0] o, f;
      ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08,
              6'h0a, 6'h0c, 6'h0d, 6'h02, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      done[g] = 1'b0;
      mon_en  = 1'b0;
      a       = blank();
      rst = 1'b1; op = 6'h0; funct = 6'h0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("dut%0d reset_state", g), 32'(state), 32'd0);
      rst = 1'b0;
      op  = 6'b100011;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("dut%0d pre_rst_memrd", g), 32'(state), 32'd3);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk($sformatf("dut%0d rst_abort_state", g), 32'(state), 32'd0);
      chk($sformatf("dut%0d rst_irwrite", g), 32'(irwrite), 32'd1);
      chk($sformatf("dut%0d rst_wr", g),
          32'({regwrite, memwrite}), 32'd0);
      a      = blank();
      mon_en = 1'b1;
      issue(6'b100011, 6'h00, 1'b0);
      issue(6'b001101, 6'h00, 1'b0);
      issue(6'b001000, 6'h00, 1'b1);
      issue(6'b000100, 6'h00, 1'b1);
      issue(6'b000100, 6'h00, 1'b0);
      issue(6'b000101, 6'h00, 1'b0);
      issue(6'b000101, 6'h00, 1'b1);
      issue(6'b000000, 6'b101010, 1'b0);
      issue(6'b000000, 6'b111111, 1'b0);
      issue(6'b111111, 6'h20, 1'b0);
      for (int i = 0; i < 150; i++) begin
        int k;
        k = $urandom_range(0, 13);
        o = (k < 11) ? ops[k] : 6'($urandom_range(0, 63));
        f = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 4)]
                                         : 6'($urandom_range(0, 63));
        issue(o, f, 1'($urandom_range(0, 1)));
      end
      mon_en = 1'b0;
      chk($sformatf("dut%0d drain", g), 32'(q.size()), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(done[0] === 1'b1 && done[1] === 1'b1);
         i++)
      @(posedge clk);
    if (!(done[0] === 1'b1 && done[1] === 1'b1)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got unfinished stimulus expected done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS-subset datapath. It sequences instruction fetch, register read, ALU, memory and writeback over 3-5 cycles per instruction. It drives every datapath select and enable, including `extop` for the 16-to-32 immediate extender: sign-extend for arithmetic, address and branch offsets; zero-extend for logical immediates. It sits between the instruction register (`op`/`funct`), the ALU zero flag and the shared ALU/memory datapath.

Parameters:
- `BNE_EN`, default 1: when 1, `bne` is decoded; when 0, `bne` is treated as illegal.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 6: IR[31:26], stable from DECODE onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag, same cycle.
- `extop` output 1: 1 = sign-extend immediate, 0 = zero-extend.
- `iord` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` output 1: data memory write enable.
- `irwrite` output 1: instruction register load.
- `regdst` output 1: destination register, 0 = rt, 1 = rd.
- `memtoreg` output 1: writeback source, 1 = memory data.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: ALU A operand, 0 = PC, 1 = register A.
- `alusrcb` output 2: ALU B operand, 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `alucontrol` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pcsrc` output 2: next-PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` output 1: PC register enable.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` output 1: one-cycle pulse in DECODE or RTEX when the opcode/funct is unsupported.
- `state` output 4: current state encoding, for debug.

Behaviour:
- **Output timing.** All outputs are combinational from the registered state plus `op`/`funct`/`zero` (Moore plus branch qualifier). The only register is `state`.
- **Reset.** `rst` high at an edge forces `state` = FETCH, aborting any instruction in flight. No partial write may occur on the cycle after reset.
- **Defaults.** In every state, any output not listed below is 0. The one exception is `extop`, which defaults to 1.
- **State encodings.** FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTEX = 6, RTWB = 7, BRANCH = 8, IMMEX = 9, IMMWB = 10, JUMP = 11. Codes 12-15 go to FETCH next cycle with all enables 0.
- **FETCH**
  - Asserts `irwrite` = 1, `pcen` = 1, `alusrcb` = 01, `alucontrol` = add.
  - Next state: DECODE.
- **DECODE**
  - Asserts `alusrcb` = 11, `alucontrol` = add (branch-target precompute).
  - Next state by `op`:
    - 100011 (`lw`) or 101011 (`sw`) -> MEMADR.
    - 000000 (R-type) -> RTEX.
    - 000100 (`beq`), or 000101 (`bne`) when `BNE_EN` = 1 -> BRANCH.
    - 001000 (`addi`), 001010 (`slti`), 001100 (`andi`), 001101 (`ori`) -> IMMEX.
    - 000010 (`j`) -> JUMP.
    - Any other opcode -> FETCH, with `illegal` = 1 and `instr_done` = 1.
- **MEMADR**
  - Asserts `alusrca` = 1, `alusrcb` = 10, add, `extop` = 1.
  - Next state: MEMRD for `lw`, MEMWR for `sw`.
- **MEMRD**
  - Asserts `iord` = 1.
  - Next state: MEMWB.
- **MEMWB**
  - Asserts `memtoreg` = 1, `regwrite` = 1, `instr_done` = 1.
  - Next state: FETCH.
- **MEMWR**
  - Asserts `iord` = 1, `memwrite` = 1, `instr_done` = 1.
  - Next state: FETCH.
- **RTEX**
  - Asserts `alusrca` = 1, `alusrcb` = 00.
  - `alucontrol` decoded from `funct`: 100000 -> add, 100010 -> sub, 100100 -> and, 100101 -> or, 101010 -> slt.
  - Next state: RTWB.
  - Unknown `funct`: `illegal` = 1, `instr_done` = 1, next state FETCH, and no RTWB write.
- **RTWB**
  - Asserts `regdst` = 1, `regwrite` = 1, `instr_done` = 1.
  - Next state: FETCH.
- **BRANCH**
  - Asserts `alusrca` = 1, `alusrcb` = 00, sub, `pcsrc` = 01, `instr_done` = 1.
  - `pcen` = `zero` for `beq`, `pcen` = ~`zero` for `bne`.
  - Next state: FETCH.
- **IMMEX**
  - Asserts `alusrca` = 1, `alusrcb` = 10.
  - Per opcode: `addi` -> add with `extop` = 1; `slti` -> slt with `extop` = 1; `andi` -> and with `extop` = 0; `ori` -> or with `extop` = 0.
  - Next state: IMMWB.
- **IMMWB**
  - Asserts `regdst` = 0, `memtoreg` = 0, `regwrite` = 1, `instr_done` = 1.
  - Next state: FETCH.
- **JUMP**
  - Asserts `pcsrc` = 10, `pcen` = 1, `instr_done` = 1.
  - Next state: FETCH.
- **Cycles per instruction.** `lw` 5; `sw`, R-type and immediate ops 4; branch and `j` 3; illegal 2.
- **Mutual exclusion.** `regwrite` and `memwrite` are never both 1. `irwrite` is 1 only in FETCH.

Test Plan:
- `rst` = 1 for 2 cycles, held in mid-MEMRD -> next cycle `state` = 0, `irwrite` = 1, `regwrite` = 0, `memwrite` = 0.
- `op` = 100011 -> state sequence 0,1,2,3,4,0; `memwrite` never 1; `regwrite` = 1 only in state 4; `instr_done` pulses once.
- `op` = 001101 then `op` = 001000 -> in IMMEX, `extop` = 0 with `alucontrol` = 001, then `extop` = 1 with `alucontrol` = 010; each instruction takes 4 cycles.
- `op` = 000100 with `zero` = 1, then `zero` = 0 -> BRANCH `pcen` = 1, then 0; `pcsrc` = 01 in both; 3 cycles each.
- `op` = 000101 with `BNE_EN` = 0 -> `illegal` pulses in DECODE and the FSM returns to FETCH after 2 cycles; with `BNE_EN` = 1 and `zero` = 0 -> `pcen` = 1.
- `op` = 000000 with `funct` = 101010, then `funct` = 111111 -> `alucontrol` = 111 then RTWB `regwrite` = 1; unknown `funct` gives `illegal` = 1 in RTEX, `regwrite` never 1, and next state 0.
